// File: rtl/ram_burst_initiator.sv
// Burst initiator for a 1R1W synchronous RAM port: write bursts stream straight to the RAM,
// read bursts return through a small credit-managed FIFO that hides the 1-cycle RAM read latency.
module ram_burst_initiator #(
   parameter int AW     = 8,
   parameter int DW     = 6,
   parameter int LW     = 8,
   parameter int FDEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid_i,
   output logic          cmd_ready_o,
   input  logic          cmd_write_i,
   input  logic [AW-1:0] cmd_addr_i,
   input  logic [LW-1:0] cmd_len_i,
   input  logic          wr_valid_i,
   output logic          wr_ready_o,
   input  logic [DW-1:0] wr_data_i,
   output logic          rd_valid_o,
   input  logic          rd_ready_i,
   output logic [DW-1:0] rd_data_o,
   output logic          rd_last_o,
   output logic          busy_o,
   output logic          done_o,
   output logic          ram_write_en_o,
   output logic [AW-1:0] ram_write_addr_o,
   output logic [DW-1:0] ram_write_data_o,
   output logic          ram_read_en_o,
   output logic [AW-1:0] ram_read_addr_o,
   input  logic [DW-1:0] ram_read_data_i
);

   localparam int PW = $clog2(FDEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] cur_q, cur_d;
   logic [LW-1:0] rem_q, rem_d;
   logic          infl_q, infl_d;
   logic          infl_last_q, infl_last_d;
   logic          done_q, done_d;

   logic [FDEPTH-1:0][DW-1:0] fifo_data_q;
   logic [FDEPTH-1:0]         fifo_last_q;
   logic [PW-1:0]             wptr_q, rptr_q;
   logic [PW:0]               cnt_q;

   logic push, pop, empty, credit_ok, beat_last;

   assign empty     = (cnt_q == '0);
   assign push      = infl_q;
   assign pop       = !empty && rd_ready_i;
   assign beat_last = (rem_q == '0);
   // A read may only issue if its data is guaranteed a FIFO slot when it returns.
   assign credit_ok = ({1'b0, cnt_q} + (PW+2)'(infl_q)) < (PW+2)'(FDEPTH);

   assign rd_valid_o  = !empty;
   assign rd_data_o   = empty ? '0 : fifo_data_q[rptr_q];
   assign rd_last_o   = empty ? 1'b0 : fifo_last_q[rptr_q];
   assign cmd_ready_o = (state_q == S_IDLE);
   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = done_q;

   always_comb begin
      state_d          = state_q;
      cur_d            = cur_q;
      rem_d            = rem_q;
      infl_d           = 1'b0;
      infl_last_d      = 1'b0;
      done_d           = 1'b0;
      wr_ready_o       = 1'b0;
      ram_write_en_o   = 1'b0;
      ram_write_addr_o = '0;
      ram_write_data_o = '0;
      ram_read_en_o    = 1'b0;
      ram_read_addr_o  = '0;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid_i) begin
               state_d = cmd_write_i ? S_WRITE : S_READ;
               cur_d   = cmd_addr_i;
               rem_d   = cmd_len_i;
            end
         end
         S_WRITE: begin
            wr_ready_o = 1'b1;
            if (wr_valid_i) begin
               ram_write_en_o   = 1'b1;
               ram_write_addr_o = cur_q;
               ram_write_data_o = wr_data_i;
               cur_d            = cur_q + AW'(1);
               rem_d            = rem_q - LW'(1);
               if (beat_last) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         S_READ: begin
            if (credit_ok) begin
               ram_read_en_o   = 1'b1;
               ram_read_addr_o = cur_q;
               infl_d          = 1'b1;
               infl_last_d     = beat_last;
               cur_d           = cur_q + AW'(1);
               rem_d           = rem_q - LW'(1);
               if (beat_last) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // The tagged final beat is the youngest entry, so popping it leaves nothing behind.
            if (pop && rd_last_o) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cur_q       <= '0;
         rem_q       <= '0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
         done_q      <= 1'b0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         rem_q       <= rem_d;
         infl_q      <= infl_d;
         infl_last_q <= infl_last_d;
         done_q      <= done_d;
         if (push) wptr_q <= wptr_q + PW'(1);
         if (pop)  rptr_q <= rptr_q + PW'(1);
         if (push && !pop)      cnt_q <= cnt_q + (PW+1)'(1);
         else if (pop && !push) cnt_q <= cnt_q - (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data_q[wptr_q] <= ram_read_data_i;
         fifo_last_q[wptr_q] <= infl_last_q;
      end
   end

endmodule

// File: tb/tb_ram_burst_initiator.sv
// Directed bench for ram_burst_initiator: cycle-by-cycle vector table plus multi-cycle burst sequences
// against a behavioural 1-cycle-latency RAM.
module tb_ram_burst_initiator;

   localparam int AW = 8;
   localparam int DW = 6;
   localparam int LW = 8;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [LW-1:0] cmd_len = '0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [DW-1:0] wr_data = '0;
   logic          rd_valid;
   logic          rd_ready = 1'b0;
   logic [DW-1:0] rd_data;
   logic          rd_last;
   logic          busy;
   logic          done;
   logic          ram_write_en;
   logic [AW-1:0] ram_write_addr;
   logic [DW-1:0] ram_write_data;
   logic          ram_read_en;
   logic [AW-1:0] ram_read_addr;
   logic [DW-1:0] ram_read_data = '0;

   always #5 clk = ~clk;

   ram_burst_initiator #(.AW(AW), .DW(DW), .LW(LW), .FDEPTH(FD)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
      .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
      .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
      .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data), .rd_last_o(rd_last),
      .busy_o(busy), .done_o(done),
      .ram_write_en_o(ram_write_en), .ram_write_addr_o(ram_write_addr), .ram_write_data_o(ram_write_data),
      .ram_read_en_o(ram_read_en), .ram_read_addr_o(ram_read_addr), .ram_read_data_i(ram_read_data)
   );

   // Behavioural RAM, preloaded with a known pattern during reset
   logic [DW-1:0] mem [256];
   logic          ram_init = 1'b0;

   function automatic logic [DW-1:0] pat(input logic [7:0] a);
      return a[5:0] ^ 6'h2A;
   endfunction

   always @(posedge clk) begin
      if (!ram_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
         ram_init <= 1'b1;
      end else begin
         if (ram_write_en) mem[ram_write_addr] <= ram_write_data;
         if (ram_read_en) ram_read_data <= mem[ram_read_addr];
      end
   end

   typedef struct packed {
      logic       cv;
      logic       cw;
      logic [7:0] ca;
      logic [7:0] cl;
      logic       wv;
      logic [5:0] wd;
      logic       rr;
   } in_t;

   typedef struct packed {
      logic       cr;
      logic       wrr;
      logic       we;
      logic [7:0] wa;
      logic [5:0] wdat;
      logic       re;
      logic [7:0] ra;
      logic       rv;
      logic [5:0] rdat;
      logic       rl;
      logic       bsy;
      logic       dn;
   } out_t;

   typedef struct {
      in_t  i;
      out_t o;
   } vec_t;

   out_t act;
   assign act = out_t'({cmd_ready, wr_ready, ram_write_en, ram_write_addr, ram_write_data,
                        ram_read_en, ram_read_addr, rd_valid, rd_data, rd_last, busy, done});

   function automatic in_t mki(input logic cv, input logic cw, input logic [7:0] ca, input logic [7:0] cl,
                               input logic wv, input logic [5:0] wd, input logic rr);
      return '{cv, cw, ca, cl, wv, wd, rr};
   endfunction

   function automatic out_t mko(input logic cr, input logic wrr, input logic we, input logic [7:0] wa,
                                input logic [5:0] wdat, input logic re, input logic [7:0] ra,
                                input logic rv, input logic [5:0] rdat, input logic rl,
                                input logic bsy, input logic dn);
      return '{cr, wrr, we, wa, wdat, re, ra, rv, rdat, rl, bsy, dn};
   endfunction

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      n_total++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, a, e);
   endtask

   task automatic apply(input in_t v);
      cmd_valid = v.cv;
      cmd_write = v.cw;
      cmd_addr  = v.ca;
      cmd_len   = v.cl;
      wr_valid  = v.wv;
      wr_data   = v.wd;
      rd_ready  = v.rr;
   endtask

   task automatic issue_cmd(input logic w, input logic [7:0] a, input logic [7:0] l);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_len   = l;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_len   = '0;
   endtask

   logic [DW-1:0] got_data[$];
   logic          got_last[$];
   logic [AW-1:0] got_ra[$];
   int            got_done;

   task automatic collect(input string nm, input int budget);
      got_data.delete();
      got_last.delete();
      got_ra.delete();
      got_done = 0;
      for (int c = 0; c < budget; c++) begin
         #1;
         if (ram_read_en) got_ra.push_back(ram_read_addr);
         if (rd_valid && rd_ready) begin
            got_data.push_back(rd_data);
            got_last.push_back(rd_last);
         end
         if (done) got_done = 1;
         if (got_done != 0) break;
         @(negedge clk);
      end
      chk({nm, "_done_seen"}, 64'(got_done), 64'd1);
      @(negedge clk);
   endtask

   vec_t          tbl[$];
   logic [7:0]    wrap_a [3] = '{8'hFE, 8'hFF, 8'h00};
   logic [5:0]    wrap_d [3] = '{6'h11, 6'h22, 6'h33};
   int            nre;
   int            nq;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      // write 0x10 len 3, data 1..4
      tbl.push_back('{mki(1,1,8'h10,8'd3,0,6'd0,0), mko(1,0,0,8'h00,6'd0,0,8'h00,0,6'd0,0,0,0)});
      tbl.push_back('{mki(0,0,8'h00,8'd0,1,6'd1,0), mko(0,1,1,8'h10,6'd1,0,8'h00,0,6'd0,0,1,0)});
      tbl.push_back('{mki(0,0,8'h00,8'd0,1,6'd2,0), mko(0,1,1,8'h11,6'd2,0,8'h00,0,6'd0,0,1,0)});
      tbl.push_back('{mki(0,0,8'h00,8'd0,1,6'd3,0), mko(0,1,1,8'h12,6'd3,0,8'h00,0,6'd0,0,1,0)});
      tbl.push_back('{mki(0,0,8'h00,8'd0,1,6'd4,0), mko(0,1,1,8'h13,6'd4,0,8'h00,0,6'd0,0,1,0)});
      tbl.push_back('{mki(0,0,8'h00,8'd0,0,6'd0,0), mko(1,0,0,8'h00,6'd0,0,8'h00,0,6'd0,0,0,1)});
      tbl.push_back('{mki(0,0,8'h00,8'd0,0,6'd0,0), mko(1,0,0,8'h00,6'd0,0,8'h00,0,6'd0,0,0,0)});
      // write 0x40 len 1 with wr_valid toggling
      tbl.push_back('{mki(1,1,8'h40,8'd1,0,6'd0,0), mko(1,0,0,8'h00,6'd0,0,8'h00,0,6'd0,0,0,0)});
      tbl.push_back('{mki(0,0,8'h00,8'd0,0,6'd0,0), mko(0,1,0,8'h00,6'd0,0,8'h00,0,6'd0,0,1,0)});
      tbl.push_back('{mki(0,0,8'h00,8'd0,1,6'd9,0), mko(0,1,1,8'h40,6'd9,0,8'h00,0,6'd0,0,1,0)});
      tbl.push_back('{mki(0,0,8'h00,8'd0,0,6'h3F,0), mko(0,1,0,8'h00,6'd0,0,8'h00,0,6'd0,0,1,0)});
      tbl.push_back('{mki(0,0,8'h00,8'd0,1,6'd10,0), mko(0,1,1,8'h41,6'd10,0,8'h00,0,6'd0,0,1,0)});
      tbl.push_back('{mki(0,0,8'h00,8'd0,0,6'd0,0), mko(1,0,0,8'h00,6'd0,0,8'h00,0,6'd0,0,0,1)});
      // read 0x10 len 3 with consumer always ready
      tbl.push_back('{mki(1,0,8'h10,8'd3,0,6'd0,1), mko(1,0,0,8'h00,6'd0,0,8'h00,0,6'd0,0,0,0)});
      tbl.push_back('{mki(0,0,8'h00,8'd0,0,6'd0,1), mko(0,0,0,8'h00,6'd0,1,8'h10,0,6'd0,0,1,0)});
      tbl.push_back('{mki(0,0,8'h00,8'd0,0,6'd0,1), mko(0,0,0,8'h00,6'd0,1,8'h11,0,6'd0,0,1,0)});
      tbl.push_back('{mki(0,0,8'h00,8'd0,0,6'd0,1), mko(0,0,0,8'h00,6'd0,1,8'h12,1,6'd1,0,1,0)});
      tbl.push_back('{mki(0,0,8'h00,8'd0,0,6'd0,1), mko(0,0,0,8'h00,6'd0,1,8'h13,1,6'd2,0,1,0)});
      tbl.push_back('{mki(0,0,8'h00,8'd0,0,6'd0,1), mko(0,0,0,8'h00,6'd0,0,8'h00,1,6'd3,0,1,0)});
      tbl.push_back('{mki(0,0,8'h00,8'd0,0,6'd0,1), mko(0,0,0,8'h00,6'd0,0,8'h00,1,6'd4,1,1,0)});
      tbl.push_back('{mki(0,0,8'h00,8'd0,0,6'd0,0), mko(1,0,0,8'h00,6'd0,0,8'h00,0,6'd0,0,0,1)});

      // reset state
      repeat (3) @(negedge clk);
      #1;
      chk("reset_outputs", 64'(act), 64'(mko(1,0,0,8'h00,6'd0,0,8'h00,0,6'd0,0,0,0)));
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < tbl.size(); k++) begin
         apply(tbl[k].i);
         #1;
         chk($sformatf("vec%0d", k), 64'(act), 64'(tbl[k].o));
         @(negedge clk);
      end
      apply(mki(0,0,8'h00,8'd0,0,6'd0,0));

      // read 0x80 len 7 with stalled consumer: credit stops issue at FIFO depth
      issue_cmd(1'b0, 8'h80, 8'd7);
      nre = 0;
      repeat (12) begin
         #1;
         if (ram_read_en) nre++;
         @(negedge clk);
      end
      chk("stall_read_count", 64'(nre), 64'(FD));
      #1;
      chk("stall_head", 64'({rd_valid, rd_data}), 64'({1'b1, pat(8'h80)}));
      @(negedge clk);
      rd_ready = 1'b1;
      collect("len7", 60);
      chk("len7_rest_reads", 64'(got_ra.size()), 64'd4);
      chk("len7_beats", 64'(got_data.size()), 64'd8);
      nq = (got_data.size() < 8) ? got_data.size() : 8;
      for (int k = 0; k < nq; k++)
         chk($sformatf("len7_beat%0d", k), 64'({got_last[k], got_data[k]}),
             64'({(k == 7), pat(8'(8'h80 + k))}));

      // address wrap 0xFE..0x00, write then read back
      rd_ready = 1'b0;
      issue_cmd(1'b1, 8'hFE, 8'd2);
      for (int k = 0; k < 3; k++) begin
         wr_valid = 1'b1;
         wr_data  = wrap_d[k];
         #1;
         chk($sformatf("wrap_wr%0d", k), 64'({ram_write_en, ram_write_addr, ram_write_data}),
             64'({1'b1, wrap_a[k], wrap_d[k]}));
         @(negedge clk);
      end
      wr_valid = 1'b0;
      #1;
      chk("wrap_wr_done", 64'({done, busy}), 64'b10);
      @(negedge clk);
      rd_ready = 1'b1;
      issue_cmd(1'b0, 8'hFE, 8'd2);
      collect("wrap_rd", 30);
      chk("wrap_rd_beats", 64'(got_data.size()), 64'd3);
      chk("wrap_rd_reads", 64'(got_ra.size()), 64'd3);
      nq = (got_ra.size() < 3) ? got_ra.size() : 3;
      for (int k = 0; k < nq; k++)
         chk($sformatf("wrap_rd_addr%0d", k), 64'(got_ra[k]), 64'(wrap_a[k]));
      nq = (got_data.size() < 3) ? got_data.size() : 3;
      for (int k = 0; k < nq; k++)
         chk($sformatf("wrap_rd_beat%0d", k), 64'({got_last[k], got_data[k]}),
             64'({(k == 2), wrap_d[k]}));

      // reset mid read burst with FIFO partly full
      rd_ready = 1'b0;
      issue_cmd(1'b0, 8'h20, 8'd7);
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_outputs", 64'(act), 64'(mko(1,0,0,8'h00,6'd0,0,8'h00,0,6'd0,0,0,0)));
      @(negedge clk);
      rst_n = 1'b1;
      rd_ready = 1'b1;
      nre = 0;
      repeat (4) begin
         #1;
         if (done || rd_valid || busy || ram_read_en) nre++;
         @(negedge clk);
      end
      chk("post_rst_quiet", 64'(nre), 64'd0);
      issue_cmd(1'b0, 8'h10, 8'd0);
      collect("post_rst_rd", 20);
      chk("post_rst_beats", 64'(got_data.size()), 64'd1);
      chk("post_rst_reads", 64'(got_ra.size()), 64'd1);
      if (got_data.size() > 0)
         chk("post_rst_beat", 64'({got_last[0], got_data[0]}), 64'({1'b1, 6'd1}));
      if (got_ra.size() > 0)
         chk("post_rst_addr", 64'(got_ra[0]), 64'h10);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
